lut_prober: RTL and testbench

LUT_PROBER -- requirements
Module: lut_prober

---
 rtl/lut_prober.sv | 107 ++++++++++
 tb/tb_lut_prober.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lut_prober.sv
`default_nettype none
// ============================================================================
// Module      : lut_prober
// Description : Characterises an attached 2-input logic unit. It walks the
//               inputs {a,b} through 00, 01, 10, 11, waits SETTLE cycles on
//               each and samples the unit output. It then reports the
//               recovered 4-bit truth table and compares it against an
//               expected value that was latched at start.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_prober #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [3:0] expect_i,
  input  logic       probe_in_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       valid_o,
  output logic [3:0] func_found_o,
  output logic       match_o
);

  localparam logic [3:0] C_SETTLE = 4'(SETTLE);

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  state_t     state_q;
  logic [1:0] idx_q;
  logic [3:0] cnt_q;
  logic [3:0] cap_q;
  logic [3:0] cap_d;
  logic [3:0] exp_q;
  logic       done_q;
  logic       valid_q;
  logic [3:0] func_q;

  // Capture vector with the bit for the current index folded in, so the final
  // sample can go straight into the result register at the completion edge.
  always_comb begin
    cap_d        = cap_q;
    cap_d[idx_q] = probe_in_i;
  end

  // Probe sequencer: accept in IDLE, step through the four input combinations,
  // publish the table and pulse done when the last sample is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      cap_q   <= 4'd0;
      exp_q   <= 4'd0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      func_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= PROBE;
            idx_q   <= 2'd0;
            cnt_q   <= C_SETTLE;
            exp_q   <= expect_i;
            valid_q <= 1'b0;
          end
        end
        PROBE: begin
          if (cnt_q == 4'd1) begin
            cap_q <= cap_d;
            if (idx_q == 2'd3) begin
              func_q  <= cap_d;
              valid_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 2'd1;
              cnt_q <= C_SETTLE;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only; a/b rest at 0 in IDLE.
  assign busy_o       = (state_q == PROBE);
  assign a_o          = (state_q == PROBE) & idx_q[1];
  assign b_o          = (state_q == PROBE) & idx_q[0];
  assign done_o       = done_q;
  assign valid_o      = valid_q;
  assign func_found_o = func_q;
  assign match_o      = valid_q & (func_q == exp_q);

endmodule
`default_nettype wire

// File: tb/tb_lut_prober.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut_prober
// Description : Self-checking bench for lut_prober. Three instances run with
//               SETTLE = 1, 2 and 15, each attached to a modelled logic unit
//               whose truth table the bench chooses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_prober;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start = 3'b000;
  logic [11:0] expv = 12'd0;
  logic [11:0] func = 12'd0;

  wire  [2:0]  a, b, busy, done, valid, match, probe;
  wire  [11:0] ff;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected registered results per instance.
  logic [3:0] m_ff    [3];
  logic       m_valid [3];
  logic       m_match [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 1 : ((g == 1) ? 2 : 15);
    wire [3:0] fn;
    assign fn       = func[4*g +: 4];
    assign probe[g] = fn[{a[g], b[g]}];

    lut_prober #(.SETTLE(S)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start[g]),
      .expect_i    (expv[4*g +: 4]),
      .probe_in_i  (probe[g]),
      .a_o         (a[g]),
      .b_o         (b[g]),
      .busy_o      (busy[g]),
      .done_o      (done[g]),
      .valid_o     (valid[g]),
      .func_found_o(ff[4*g +: 4]),
      .match_o     (match[g])
    );
  end

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 15);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      m_ff[d]    = 4'd0;
      m_valid[d] = 1'b0;
      m_match[d] = 1'b0;
    end
  endtask

  task automatic check_zero(input int d, input string tag);
    chk({tag, ".a"},     32'(a[d]), 0);
    chk({tag, ".b"},     32'(b[d]), 0);
    chk({tag, ".busy"},  32'(busy[d]), 0);
    chk({tag, ".done"},  32'(done[d]), 0);
    chk({tag, ".valid"}, 32'(valid[d]), 0);
    chk({tag, ".ff"},    32'(ff[4*d +: 4]), 0);
    chk({tag, ".match"}, 32'(match[d]), 0);
  endtask

  // Idle cycles: nothing moves, results stay as last reported.
  task automatic idle_check(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle.busy",  32'(busy[d]), 0);
      chk("idle.done",  32'(done[d]), 0);
      chk("idle.ab",    32'({a[d], b[d]}), 0);
      chk("idle.valid", 32'(valid[d]), 32'(m_valid[d]));
      chk("idle.ff",    32'(ff[4*d +: 4]), 32'(m_ff[d]));
      chk("idle.match", 32'(match[d]), 32'(m_match[d]));
    end
  endtask

  // One probe run on instance d. Called at a negedge; start is raised so the
  // following rising edge accepts. Cycle k means "after edge E0+k".
  task automatic run(input int d, input logic [3:0] f, input logic [3:0] e,
                     input bit hold, input int glitch_k, input int abort_k);
    int s;
    int idx;
    s = settle_of(d);
    func[4*d +: 4] = f;
    expv[4*d +: 4] = e;
    start[d] = 1'b1;
    for (int k = 0; k <= 4*s; k++) begin
      @(negedge clk);
      if (k < 4*s) begin
        idx = k / s;
        chk("run.a",     32'(a[d]), 32'((idx >> 1) & 1));
        chk("run.b",     32'(b[d]), 32'(idx & 1));
        chk("run.busy",  32'(busy[d]), 1);
        chk("run.done",  32'(done[d]), 0);
        chk("run.valid", 32'(valid[d]), 0);
        chk("run.ff",    32'(ff[4*d +: 4]), 32'(m_ff[d]));
        chk("run.match", 32'(match[d]), 0);
      end else begin
        m_ff[d]    = f;
        m_valid[d] = 1'b1;
        m_match[d] = (f == e);
        chk("end.done",  32'(done[d]), 1);
        chk("end.busy",  32'(busy[d]), 0);
        chk("end.ab",    32'({a[d], b[d]}), 0);
        chk("end.valid", 32'(valid[d]), 1);
        chk("end.ff",    32'(ff[4*d +: 4]), 32'(f));
        chk("end.match", 32'(match[d]), 32'(m_match[d]));
      end
      if (k == 0 && !hold) start[d] = 1'b0;
      if (k == glitch_k)     start[d] = 1'b1;
      if (k == glitch_k + 1) start[d] = 1'b0;
      if (k == abort_k) begin
        rst = 1'b1;
        start[d] = 1'b0;
        @(negedge clk);
        check_zero(d, "abort");
        rst = 1'b0;
        clear_model();
        return;
      end
    end
  endtask

  initial begin
    int d;
    logic [3:0] f, e;
    clear_model();

    // Reset state for every instance.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    rst = 1'b0;

    // XOR, SETTLE=2, immediately after reset release.
    run(1, 4'b0110, 4'b0110, 1'b0, -10, -10);
    idle_check(1, 2);

    // AND with wrong expectation, then with the right one.
    run(1, 4'b1000, 4'b0110, 1'b0, -10, -10);
    run(1, 4'b1000, 4'b1000, 1'b0, -10, -10);

    // start held high, SETTLE=1: back-to-back accepts every 5 cycles.
    run(0, 4'b0110, 4'b0110, 1'b1, -10, -10);
    run(0, 4'b1001, 4'b0110, 1'b1, -10, -10);
    run(0, 4'b0111, 4'b0111, 1'b0, -10, -10);
    idle_check(0, 2);

    // Extra start pulse during a run is ignored; exactly one done.
    run(1, 4'b0010, 4'b0010, 1'b0, 2, -10);
    func[4 +: 4] = 4'b1101;
    idle_check(1, 6);

    // Reset mid-run after a previous result of 1110, then a fresh run.
    run(1, 4'b1110, 4'b1110, 1'b0, -10, -10);
    run(1, 4'b0001, 4'b0001, 1'b0, -10, 4);
    idle_check(1, 1);
    run(1, 4'b0100, 4'b0100, 1'b0, -10, -10);

    // SETTLE=15: 1111 then 0000, previous result held during the second run.
    run(2, 4'b1111, 4'b1111, 1'b0, -10, -10);
    run(2, 4'b0000, 4'b1111, 1'b0, -10, -10);

    // Randomised runs across all instances.
    for (int r = 0; r < 24; r++) begin
      d = $urandom_range(0, 2);
      f = 4'($urandom);
      e = ($urandom_range(0, 1) == 1) ? f : 4'($urandom);
      run(d, f, e, 1'b0, -10, -10);
      idle_check(d, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
